branch_predictor_gshare: RTL and testbench
==========================================

# branch_predictor_gshare

Parametrised successor to the fixed-size `branch_predictor`, sitting in the fetch stage. It classifies the fetched RV32 instruction and predicts direction one cycle later. Direction comes from a table of saturating counters, indexed by PC optionally XORed with a speculative global history register (GHR). Resolution from execute trains the table, repairs the GHR on mispredict, and feeds performance counters.

## Interface
- PHT_DEPTH, 256, counter entries; power of two, ≥ 4; IDX_W = log2(PHT_DEPTH)
- HIST_W, 8, GHR width; 1 ≤ HIST_W ≤ IDX_W
- CTR_W, 2, saturating counter width; ≥ 2
- STAT_W, 32, performance counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- lookup_valid  in  1  pc/instruction valid this cycle
- pc  in  32  fetch address
- instruction  in  32  fetched instruction
- is_branch_predicted  out  1  registered: looked-up instruction is branch/JAL/JALR
- prediction  out  1  registered: predicted taken
- pred_index  out  IDX_W  registered: PHT index used; travels down pipeline
- pred_ghr  out  HIST_W  registered: GHR value before this lookup's speculative shift
- upd_valid  in  1  resolution valid
- upd_is_cond  in  1  resolved instruction was conditional (opcode 1100011)
- upd_index  in  IDX_W  pred_index carried from lookup
- upd_ghr  in  HIST_W  pred_ghr carried from lookup
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  prediction differed from actual
- stat_lookups  out  STAT_W  count of lookups with is_branch classification 1
- stat_mispredicts  out  STAT_W  count of upd_valid && upd_mispredict

## Operation
- Classification uses instruction[6:0]:
  - 1100011 → conditional
  - 1101111 (JAL) or 1100111 (JALR) → unconditional
  - all other opcodes → non-branch
- Index = pc[IDX_W+1:2] XOR {zero-extend GHR} when the history feature is compiled in (see Configuration).
- Conditional: prediction = MSB of PHT[index]. The GHR shifts left with the predicted bit entering at bit 0.
- Unconditional: prediction = 1. No PHT read effect. GHR unchanged.
- Non-branch, or lookup_valid = 0: prediction = 0, is_branch_predicted = 0. GHR unchanged. pred_index and pred_ghr still load their computed values.
- Update with upd_valid && upd_is_cond: PHT[upd_index] increments if upd_taken, otherwise decrements, saturating at 0 and 2^CTR_W−1.
- Update with upd_valid && upd_mispredict: GHR ← {upd_ghr[HIST_W−2:0], upd_taken}. Applied for both conditional and unconditional.
- Unconditional updates never touch the PHT.
- Stat counters wrap modulo 2^STAT_W.

## Timing
- Lookup latency is 1 cycle. Inputs are sampled at edge N; outputs are valid after edge N and held until the next edge.
- Reset values:
  - all outputs 0
  - GHR 0
  - every PHT entry 2^(CTR_W−1)−1 (weakly not-taken; 01 for CTR_W = 2)
  - stat counters 0
- Reset is asserted asynchronously; release is synchronous to clk. A lookup or update in flight at reset is discarded.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update counter (no bypass). The write lands at the same edge.
- Simultaneous mispredict repair and conditional lookup: the repair wins and the lookup's speculative shift is dropped. The lookup's outputs still use the pre-edge GHR.
- Counter saturation: taken at max holds max; not-taken at 0 holds 0.
- GHR wrap: the oldest bit is discarded on each shift.

## Configuration
- BP_GSHARE_EN defined:
  - GHR exists; index = PC bits XOR GHR
  - speculative shift and repair operate as above
- BP_GSHARE_EN undefined (bimodal):
  - no GHR; index = pc[IDX_W+1:2]
  - pred_ghr tied 0; upd_ghr and upd_mispredict ignored for history (upd_mispredict still counts in stat_mispredicts)

## Test plan
- Reset release, no updates; lookup conditional 0x00208463 at pc 0x80000004 → next cycle is_branch_predicted = 1, prediction = 0, stat_lookups = 1.
- Bimodal, pc 0x80000004: one upd_taken at that index → next lookup prediction = 1. Four more taken, then one not-taken → prediction still 1. Two more not-taken → prediction 0.
- JAL 0x1000006F and JALR 0x000100E7 → prediction = 1, is_branch_predicted = 1, GHR/pred_ghr unchanged. R-type 0x002081B3 → both outputs 0, stat_lookups unchanged.
- BP_GSHARE_EN, GHR 0:
  - three conditional lookups predicting 0 → pred_ghr = 0x00 each, GHR 0x00
  - then mispredict with upd_ghr = 0x05, upd_taken = 1 on the same cycle as a lookup → GHR = 0x0B next cycle; stat_mispredicts = 1
- Same-index lookup and taken update in one cycle, counter 01 → prediction 0 that cycle, 1 on the following lookup.
- Reset driven low mid-sequence after training → outputs 0 immediately (asynchronous), and the PHT returns to 01 (trained pc predicts 0 after release).

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare
//
// Fetch-stage direction predictor. Classifies the fetched RV32 instruction
// by opcode and, one cycle later, presents a taken/not-taken prediction taken
// from a table of saturating counters (PHT). The PHT index is the word-aligned
// PC, optionally XORed with a speculative global history register (GHR).
// Resolution from execute trains the PHT, repairs the GHR after a mispredict,
// and drives two performance counters.
//
// Compile-time option:
//   BP_GSHARE_EN  defined   -> gshare: GHR present, index = pc bits ^ GHR
//                 undefined -> bimodal: no GHR, index = pc bits, pred_ghr_o = 0
//
// Parameters:
//   PHT_DEPTH  counter entries (power of two, >= 4); IDX_W = log2(PHT_DEPTH)
//   HIST_W     GHR width (1 .. IDX_W)
//   CTR_W      saturating counter width (>= 2)
//   STAT_W     performance counter width
//
// Ports:
//   clk_i                  clock, all state updates on the rising edge
//   rst_ni                 asynchronous active-low reset (release is synchronous)
//   lookup_valid_i         pc_i / instruction_i valid this cycle
//   pc_i                   fetch address
//   instruction_i          fetched instruction
//   is_branch_predicted_o  registered: instruction was branch / JAL / JALR
//   prediction_o           registered: predicted taken
//   pred_index_o           registered: PHT index used by the lookup
//   pred_ghr_o             registered: GHR before the lookup's speculative shift
//   upd_valid_i            resolution valid
//   upd_is_cond_i          resolved instruction was a conditional branch
//   upd_index_i            pred_index_o carried down the pipeline
//   upd_ghr_i              pred_ghr_o carried down the pipeline
//   upd_taken_i            actual direction
//   upd_mispredict_i       prediction differed from the actual direction
//   stat_lookups_o         lookups classified as branch / jump (wraps)
//   stat_mispredicts_o     resolutions flagged as mispredicted (wraps)
//
// Handshake: there is no back-pressure. A lookup is accepted on every rising
// edge where lookup_valid_i is high, and an update on every rising edge where
// upd_valid_i is high; both may occur in the same cycle.
// ---------------------------------------------------------------------------
module branch_predictor_gshare #(
    parameter int unsigned PHT_DEPTH = 256,
    parameter int unsigned HIST_W    = 8,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned STAT_W    = 32,
    localparam int unsigned IDX_W    = $clog2(PHT_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              lookup_valid_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       instruction_i,
    output logic              is_branch_predicted_o,
    output logic              prediction_o,
    output logic [IDX_W-1:0]  pred_index_o,
    output logic [HIST_W-1:0] pred_ghr_o,

    input  logic              upd_valid_i,
    input  logic              upd_is_cond_i,
    input  logic [IDX_W-1:0]  upd_index_i,
    input  logic [HIST_W-1:0] upd_ghr_i,
    input  logic              upd_taken_i,
    input  logic              upd_mispredict_i,

    output logic [STAT_W-1:0] stat_lookups_o,
    output logic [STAT_W-1:0] stat_mispredicts_o
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN  = {CTR_W{1'b0}};
    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

    // -----------------------------------------------------------------------
    // Instruction classification
    // -----------------------------------------------------------------------
    logic [6:0] opcode;
    logic       is_cond;
    logic       is_uncond;
    logic       lookup_branch;

    assign opcode        = instruction_i[6:0];
    assign is_cond       = (opcode == OPC_BRANCH);
    assign is_uncond     = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign lookup_branch = lookup_valid_i && (is_cond || is_uncond);

    // -----------------------------------------------------------------------
    // Pattern history table storage
    // -----------------------------------------------------------------------
    logic [CTR_W-1:0] pht_q [PHT_DEPTH];

    // -----------------------------------------------------------------------
    // Global history (gshare build only)
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] ghr_ext;     // GHR zero-extended to index width
    logic [IDX_W-1:0] lookup_idx;
    logic [CTR_W-1:0] lookup_ctr;
    logic             lookup_ctr_taken;

    assign lookup_idx       = pc_i[IDX_W+1:2] ^ ghr_ext;
    assign lookup_ctr       = pht_q[lookup_idx];
    assign lookup_ctr_taken = lookup_ctr[CTR_W-1];

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_d;
    logic [HIST_W-1:0] pred_ghr_q;

    always_comb begin
        ghr_ext               = '0;
        ghr_ext[HIST_W-1:0]   = ghr_q;
    end

    // Repair has priority over the speculative shift: the history rebuilt
    // from the resolved branch is authoritative, so a lookup in the same
    // cycle loses its shift. The oldest bit falls off the top on each shift.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid_i && upd_mispredict_i) begin
            ghr_d = (upd_ghr_i << 1) | HIST_W'(upd_taken_i);
        end else if (lookup_valid_i && is_cond) begin
            ghr_d = (ghr_q << 1) | HIST_W'(lookup_ctr_taken);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q      <= '0;
            pred_ghr_q <= '0;
        end else begin
            ghr_q      <= ghr_d;
            pred_ghr_q <= ghr_q;
        end
    end

    assign pred_ghr_o = pred_ghr_q;
`else
    // Bimodal: no history; the carried history input has no consumer.
    logic unused_ghr;

    assign ghr_ext    = '0;
    assign pred_ghr_o = '0;
    assign unused_ghr = ^upd_ghr_i;
`endif

    // -----------------------------------------------------------------------
    // Lookup output registers
    // -----------------------------------------------------------------------
    logic             is_branch_q, is_branch_d;
    logic             prediction_q, prediction_d;
    logic [IDX_W-1:0] pred_index_q;

    always_comb begin
        is_branch_d  = 1'b0;
        prediction_d = 1'b0;
        if (lookup_valid_i) begin
            if (is_cond) begin
                is_branch_d  = 1'b1;
                prediction_d = lookup_ctr_taken;
            end else if (is_uncond) begin
                is_branch_d  = 1'b1;
                prediction_d = 1'b1;
            end
        end
    end

    // pred_index loads every cycle, including non-branch and idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_branch_q  <= 1'b0;
            prediction_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            is_branch_q  <= is_branch_d;
            prediction_q <= prediction_d;
            pred_index_q <= lookup_idx;
        end
    end

    assign is_branch_predicted_o = is_branch_q;
    assign prediction_o          = prediction_q;
    assign pred_index_o          = pred_index_q;

    // -----------------------------------------------------------------------
    // PHT training
    // -----------------------------------------------------------------------
    // The lookup read above uses pht_q directly, so a same-cycle lookup of the
    // entry being trained sees the pre-update value; the write lands at the
    // same edge.
    logic             pht_we;
    logic [CTR_W-1:0] upd_ctr;
    logic [CTR_W-1:0] upd_ctr_d;

    assign pht_we  = upd_valid_i && upd_is_cond_i;
    assign upd_ctr = pht_q[upd_index_i];

    always_comb begin
        upd_ctr_d = upd_ctr;
        if (upd_taken_i) begin
            if (upd_ctr != CTR_MAX) begin
                upd_ctr_d = upd_ctr + CTR_W'(1);
            end
        end else begin
            if (upd_ctr != CTR_MIN) begin
                upd_ctr_d = upd_ctr - CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(PHT_DEPTH); i++) begin
                pht_q[i] <= CTR_INIT;
            end
        end else if (pht_we) begin
            pht_q[upd_index_i] <= upd_ctr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters (wrap modulo 2^STAT_W)
    // -----------------------------------------------------------------------
    logic [STAT_W-1:0] stat_lookups_q, stat_lookups_d;
    logic [STAT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (lookup_branch) begin
            stat_lookups_d = stat_lookups_q + STAT_W'(1);
        end
        // Counted in both builds, regardless of whether history is repaired.
        if (upd_valid_i && upd_mispredict_i) begin
            stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_lookups_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups_o     = stat_lookups_q;
    assign stat_mispredicts_o = stat_mispredicts_q;

    // -----------------------------------------------------------------------
    // Instruction and PC bits that play no part in prediction
    // -----------------------------------------------------------------------
    logic unused_bits;
    assign unused_bits = ^{pc_i[31:IDX_W+2], pc_i[1:0], instruction_i[31:7]};

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_gshare
//
// Directed bench for branch_predictor_gshare with default parameters
// (PHT_DEPTH 256, HIST_W 8, CTR_W 2, STAT_W 32). Covers reset state,
// classification, bimodal counter training and saturation, same-index
// lookup/update ordering, asynchronous reset mid-sequence and, when
// BP_GSHARE_EN is defined, speculative history and mispredict repair.
// ---------------------------------------------------------------------------
module tb_branch_predictor_gshare;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    // -----------------------------------------------------------------------
    // DUT
    // -----------------------------------------------------------------------
    logic        lookup_valid_i;
    logic [31:0] pc_i;
    logic [31:0] instruction_i;
    logic        is_branch_predicted_o;
    logic        prediction_o;
    logic [7:0]  pred_index_o;
    logic [7:0]  pred_ghr_o;
    logic        upd_valid_i;
    logic        upd_is_cond_i;
    logic [7:0]  upd_index_i;
    logic [7:0]  upd_ghr_i;
    logic        upd_taken_i;
    logic        upd_mispredict_i;
    logic [31:0] stat_lookups_o;
    logic [31:0] stat_mispredicts_o;

    branch_predictor_gshare dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .lookup_valid_i        (lookup_valid_i),
        .pc_i                  (pc_i),
        .instruction_i         (instruction_i),
        .is_branch_predicted_o (is_branch_predicted_o),
        .prediction_o          (prediction_o),
        .pred_index_o          (pred_index_o),
        .pred_ghr_o            (pred_ghr_o),
        .upd_valid_i           (upd_valid_i),
        .upd_is_cond_i         (upd_is_cond_i),
        .upd_index_i           (upd_index_i),
        .upd_ghr_i             (upd_ghr_i),
        .upd_taken_i           (upd_taken_i),
        .upd_mispredict_i      (upd_mispredict_i),
        .stat_lookups_o        (stat_lookups_o),
        .stat_mispredicts_o    (stat_mispredicts_o)
    );

    // -----------------------------------------------------------------------
    // Stimulus constants
    // -----------------------------------------------------------------------
    localparam logic [31:0] I_BEQ  = 32'h0020_8463;
    localparam logic [31:0] I_JAL  = 32'h1000_006F;
    localparam logic [31:0] I_JALR = 32'h0001_00E7;
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;

    int total = 0;
    int bad   = 0;

    // -----------------------------------------------------------------------
    // Checker
    // -----------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic idle();
        lookup_valid_i   = 1'b0;
        pc_i             = 32'h0;
        instruction_i    = 32'h0;
        upd_valid_i      = 1'b0;
        upd_is_cond_i    = 1'b0;
        upd_index_i      = 8'h0;
        upd_ghr_i        = 8'h0;
        upd_taken_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] ins);
        lookup_valid_i = 1'b1;
        pc_i           = pc;
        instruction_i  = ins;
    endtask

    task automatic update(input logic [7:0] idx, input logic [7:0] ghr,
                          input logic cond, input logic taken, input logic misp);
        upd_valid_i      = 1'b1;
        upd_index_i      = idx;
        upd_ghr_i        = ghr;
        upd_is_cond_i    = cond;
        upd_taken_i      = taken;
        upd_mispredict_i = misp;
    endtask

    // One rising edge, then sample 1 time unit later and return to idle.
    task automatic step();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    // Called 1 unit after an edge, so both reset transitions stay clear of edges.
    task automatic pulse_reset();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        idle();

        // Reset state
        #12;
        chk("rst_is_branch", 32'(is_branch_predicted_o), 32'h0);
        chk("rst_prediction", 32'(prediction_o), 32'h0);
        chk("rst_pred_index", 32'(pred_index_o), 32'h0);
        chk("rst_pred_ghr", 32'(pred_ghr_o), 32'h0);
        chk("rst_stat_lookups", stat_lookups_o, 32'h0);
        chk("rst_stat_mispredicts", stat_mispredicts_o, 32'h0);
        rst_ni = 1'b1;

        // First conditional lookup, PHT all weakly not-taken; index = 1
        lookup(32'h8000_0004, I_BEQ);
        step();
        chk("first_is_branch", 32'(is_branch_predicted_o), 32'h1);
        chk("first_prediction", 32'(prediction_o), 32'h0);
        chk("first_pred_index", 32'(pred_index_o), 32'h01);
        chk("first_pred_ghr", 32'(pred_ghr_o), 32'h00);
        chk("first_stat_lookups", stat_lookups_o, 32'd1);

`ifndef BP_GSHARE_EN
        // Bimodal training at index 1: 01 -> 10
        update(8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        step();
        chk("idle_is_branch", 32'(is_branch_predicted_o), 32'h0);
        chk("idle_prediction", 32'(prediction_o), 32'h0);
        lookup(32'h8000_0004, I_BEQ);
        step();
        chk("train1_prediction", 32'(prediction_o), 32'h1);
        chk("train1_stat_lookups", stat_lookups_o, 32'd2);

        // Four taken saturate at 11, one not-taken -> 10
        for (int i = 0; i < 4; i++) begin
            update(8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
            step();
        end
        update(8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        step();
        lookup(32'h8000_0004, I_BEQ);
        step();
        chk("sat_prediction", 32'(prediction_o), 32'h1);

        // Two more not-taken: 10 -> 01 -> 00
        for (int i = 0; i < 2; i++) begin
            update(8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
            step();
        end
        lookup(32'h8000_0004, I_BEQ);
        step();
        chk("untrain_prediction", 32'(prediction_o), 32'h0);
        chk("untrain_stat_lookups", stat_lookups_o, 32'd4);

        // Mispredict in bimodal: counted, no history effect
        lookup(32'h8000_0008, I_BEQ);
        update(8'h33, 8'h05, 1'b0, 1'b1, 1'b1);
        step();
        chk("bim_misp_pred_ghr", 32'(pred_ghr_o), 32'h00);
        chk("bim_misp_stat", stat_mispredicts_o, 32'd1);
        chk("bim_misp_pred_index", 32'(pred_index_o), 32'h02);
        lookup(32'h8000_0008, I_BEQ);
        step();
        chk("bim_after_pred_ghr", 32'(pred_ghr_o), 32'h00);
        chk("bim_after_pred_index", 32'(pred_index_o), 32'h02);
`else
        // Three not-taken conditional lookups leave the GHR at 0
        lookup(32'h8000_0010, I_BEQ);
        step();
        chk("gs_l1_pred_ghr", 32'(pred_ghr_o), 32'h00);
        chk("gs_l1_prediction", 32'(prediction_o), 32'h0);
        lookup(32'h8000_0020, I_BEQ);
        step();
        chk("gs_l2_pred_ghr", 32'(pred_ghr_o), 32'h00);
        lookup(32'h8000_0030, I_BEQ);
        step();
        chk("gs_l3_pred_ghr", 32'(pred_ghr_o), 32'h00);
        chk("gs_l3_stat_lookups", stat_lookups_o, 32'd4);

        // Repair with lookup in the same cycle: GHR <- {0x05, 1} = 0x0B
        lookup(32'h8000_0050, I_BEQ);
        update(8'h00, 8'h05, 1'b0, 1'b1, 1'b1);
        step();
        chk("gs_rep_pred_ghr", 32'(pred_ghr_o), 32'h00);
        chk("gs_rep_pred_index", 32'(pred_index_o), 32'h14);
        chk("gs_rep_stat_misp", stat_mispredicts_o, 32'd1);
        lookup(32'h8000_0004, I_BEQ);
        step();
        chk("gs_after_rep_ghr", 32'(pred_ghr_o), 32'h0B);
        chk("gs_after_rep_index", 32'(pred_index_o), 32'h0A);
        chk("gs_after_rep_pred", 32'(prediction_o), 32'h0);
        // Speculative shift of a 0: 0x0B -> 0x16
        lookup(32'h8000_0004, I_BEQ);
        step();
        chk("gs_shift_ghr", 32'(pred_ghr_o), 32'h16);
        chk("gs_shift_index", 32'(pred_index_o), 32'h17);
        // Repair discards the oldest bit: {0xFF, 0} -> 0xFE
        update(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        step();
        lookup(32'h8000_0004, I_BEQ);
        step();
        chk("gs_wrap_ghr", 32'(pred_ghr_o), 32'hFE);
        chk("gs_wrap_index", 32'(pred_index_o), 32'hFF);
`endif

        // Clean state for the build-independent part
        pulse_reset();
        chk("pulse_stat_lookups", stat_lookups_o, 32'd0);

        // Unconditional jumps and a non-branch
        lookup(32'h8000_0100, I_JAL);
        step();
        chk("jal_is_branch", 32'(is_branch_predicted_o), 32'h1);
        chk("jal_prediction", 32'(prediction_o), 32'h1);
        chk("jal_pred_ghr", 32'(pred_ghr_o), 32'h00);
        chk("jal_stat_lookups", stat_lookups_o, 32'd1);
        lookup(32'h8000_0104, I_JALR);
        step();
        chk("jalr_is_branch", 32'(is_branch_predicted_o), 32'h1);
        chk("jalr_prediction", 32'(prediction_o), 32'h1);
        chk("jalr_pred_ghr", 32'(pred_ghr_o), 32'h00);
        lookup(32'h8000_0108, I_ADD);
        step();
        chk("rtype_is_branch", 32'(is_branch_predicted_o), 32'h0);
        chk("rtype_prediction", 32'(prediction_o), 32'h0);
        chk("rtype_pred_ghr", 32'(pred_ghr_o), 32'h00);
        chk("rtype_pred_index", 32'(pred_index_o), 32'h42);
        chk("rtype_stat_lookups", stat_lookups_o, 32'd2);

        // Same-index lookup and taken update: lookup sees old 01
        lookup(32'h8000_0040, I_BEQ);
        update(8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
        step();
        chk("same_idx_pred_old", 32'(prediction_o), 32'h0);
        chk("same_idx_index", 32'(pred_index_o), 32'h10);
        lookup(32'h8000_0040, I_BEQ);
        step();
        chk("same_idx_pred_new", 32'(prediction_o), 32'h1);
        chk("same_idx_stat_lookups", stat_lookups_o, 32'd4);

        // Train further, leave outputs non-zero, then reset mid-cycle
        update(8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
        step();
        lookup(32'h8000_0100, I_JAL);
        step();
        chk("pre_rst_prediction", 32'(prediction_o), 32'h1);
        rst_ni = 1'b0;
        #2;
        chk("async_rst_is_branch", 32'(is_branch_predicted_o), 32'h0);
        chk("async_rst_prediction", 32'(prediction_o), 32'h0);
        chk("async_rst_pred_index", 32'(pred_index_o), 32'h0);
        chk("async_rst_stat_lookups", stat_lookups_o, 32'd0);
        rst_ni = 1'b1;
        lookup(32'h8000_0040, I_BEQ);
        step();
        chk("post_rst_prediction", 32'(prediction_o), 32'h0);
        chk("post_rst_pred_index", 32'(pred_index_o), 32'h10);
        chk("post_rst_stat_lookups", stat_lookups_o, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
